// File: rtl/sysctrl_host_if.sv
// Signal bundle between the sysctrl byte-link initiator and its local/link neighbours.
// The master modport is the initiator's view; slave is the view of whoever drives it.
interface sysctrl_host_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_cmd;
    logic [3:0] req_len;
    logic       pl_we;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;
    logic       link_strobe;
    logic       link_start;
    logic [7:0] link_data;
    logic [7:0] link_rdata;
    logic       rsp_done;
    logic [3:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        input  req_valid, req_cmd, req_len, pl_we, pl_addr, pl_data, link_rdata, rsp_addr,
        output req_ready, link_strobe, link_start, link_data, rsp_done, rsp_data, busy
    );

    modport slave (
        output req_valid, req_cmd, req_len, pl_we, pl_addr, pl_data, link_rdata, rsp_addr,
        input  req_ready, link_strobe, link_start, link_data, rsp_done, rsp_data, busy
    );
endinterface

// File: rtl/sysctrl_host.sv
// Initiator for the MCU byte-command link: sends a command byte plus 0..15 payload bytes
// as single-cycle strobes and captures one response byte after each payload strobe.
module sysctrl_host #(
    parameter int unsigned GAP   = 2,
    parameter int unsigned DEPTH = 16
) (
    input logic           clk,
    input logic           reset,
    sysctrl_host_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StGap,
        StPayload,
        StCapture,
        StDone
    } state_e;

    localparam logic [3:0] GapLoad   = 4'(GAP);
    localparam logic [3:0] GapReload = 4'(GAP - 1);

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [3:0] len_q, len_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] gap_q, gap_d;
    logic       strobe_q, strobe_d;
    logic       start_q, start_d;
    logic [7:0] data_q, data_d;
    logic       rsp_we;

    logic [7:0] pl_mem  [DEPTH];
    logic [7:0] rsp_mem [DEPTH];

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        rsp_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    cmd_d   = bus.req_cmd;
                    len_d   = bus.req_len;
                    idx_d   = 4'd0;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (len_q == 4'd0) begin
                    state_d = StCapture;
                end else begin
                    gap_d   = GapLoad;
                    state_d = StGap;
                end
            end
            // gap_q holds the number of quiet cycles still to spend, including this one
            StGap: begin
                if (gap_q <= 4'd1) state_d = StPayload;
                else               gap_d   = gap_q - 4'd1;
            end
            StPayload: state_d = StCapture;
            StCapture: begin
                if (len_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    rsp_we = 1'b1;
                    if (idx_q == 4'(len_q - 4'd1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        // capture already served as the first quiet cycle
                        if (GAP <= 1) begin
                            state_d = StPayload;
                        end else begin
                            gap_d   = GapReload;
                            state_d = StGap;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        strobe_d = (state_d == StCmd) || (state_d == StPayload);
        start_d  = (state_d == StCmd);
        if (state_d == StCmd)          data_d = cmd_d;
        else if (state_d == StPayload) data_d = pl_mem[idx_d];
        else                           data_d = data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cmd_q    <= 8'd0;
            len_q    <= 4'd0;
            idx_q    <= 4'd0;
            gap_q    <= 4'd0;
            strobe_q <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            strobe_q <= strobe_d;
            start_q  <= start_d;
            data_q   <= data_d;
        end
    end

    // Buffers are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (bus.pl_we && (state_q == StIdle)) pl_mem[bus.pl_addr] <= bus.pl_data;
        if (rsp_we) rsp_mem[idx_q] <= bus.link_rdata;
    end

    assign bus.link_strobe = strobe_q;
    assign bus.link_start  = start_q;
    assign bus.link_data   = data_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.req_ready   = (state_q == StIdle);
    assign bus.rsp_done    = (state_q == StDone);
    assign bus.rsp_data    = rsp_mem[bus.rsp_addr];

endmodule

// File: tb/tb_sysctrl_host.sv
// Bench for sysctrl_host: table of frames run against a small responder model, expected
// strobes and completion cycles queued at drive time and checked by a monitor.
module tb_sysctrl_host;
    localparam int unsigned GAP = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sysctrl_host_if bus_if ();

    sysctrl_host #(.GAP(GAP), .DEPTH(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         rel;
        logic       start;
        logic [7:0] data;
    } strb_t;

    typedef struct {
        logic [7:0]       cmd;
        logic [3:0]       len;
        logic [15:0][7:0] pl;
        logic [15:0][7:0] rsp;
    } vec_t;

    strb_t exp_strb[$];
    int    exp_done[$];

    logic [7:0] rsp_model [16];
    bit         rsp_known [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input int rel);
        tests++;
        fails++;
        $display("FAIL %s: event at relative cycle %0d, none expected", name, rel);
    endtask

    // Responder model: echoes payload ^ 0x5A, ID read returns a fixed 3-byte signature.
    logic [7:0] r_cmd     = 8'h00;
    logic [7:0] r_out     = 8'h00;
    int         r_cnt     = 0;
    logic [1:0] leds      = 2'b00;
    logic [7:0] scanlines = 8'h00;

    always @(posedge clk) begin
        if (bus_if.link_strobe) begin
            if (bus_if.link_start) begin
                r_cmd <= bus_if.link_data;
                r_cnt <= 0;
            end else begin
                r_cnt <= r_cnt + 1;
                case (r_cmd)
                    8'h00: begin
                        case (r_cnt)
                            0:       r_out <= 8'h5C;
                            1:       r_out <= 8'h42;
                            default: r_out <= 8'h02;
                        endcase
                    end
                    8'h01: begin
                        leds  <= bus_if.link_data[1:0];
                        r_out <= bus_if.link_data ^ 8'h5A;
                    end
                    8'h04: begin
                        if (r_cnt == 1) scanlines <= bus_if.link_data;
                        r_out <= bus_if.link_data ^ 8'h5A;
                    end
                    default: r_out <= bus_if.link_data ^ 8'h5A;
                endcase
            end
        end
    end

    assign bus_if.link_rdata = r_out;

    // Monitor
    logic  prev_strb = 1'b0;
    strb_t mon_e;
    int    mon_d;

    always @(negedge clk) begin
        prev_strb <= bus_if.link_strobe;
        if (!reset) begin
            check("start_implies_strobe", 32'(bus_if.link_start & ~bus_if.link_strobe), 0);
            check("strobe_one_cycle", 32'(prev_strb & bus_if.link_strobe), 0);
            if (bus_if.link_strobe) begin
                if (exp_strb.size() == 0) begin
                    note_fail("unexpected_strobe", cyc - t0);
                end else begin
                    mon_e = exp_strb.pop_front();
                    check("strobe_cycle", cyc - t0, mon_e.rel);
                    check("strobe_start", 32'(bus_if.link_start), 32'(mon_e.start));
                    check("strobe_data", 32'(bus_if.link_data), 32'(mon_e.data));
                end
            end
            if (bus_if.rsp_done) begin
                if (exp_done.size() == 0) begin
                    note_fail("unexpected_rsp_done", cyc - t0);
                end else begin
                    mon_d = exp_done.pop_front();
                    check("done_cycle", cyc - t0, mon_d);
                end
            end
        end
    end

    task automatic write_payload(input vec_t v);
        for (int k = 0; k < int'(v.len); k++) begin
            @(negedge clk);
            bus_if.pl_we   = 1'b1;
            bus_if.pl_addr = 4'(k);
            bus_if.pl_data = v.pl[k];
        end
        @(negedge clk);
        bus_if.pl_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_expect(input vec_t v, input int nstrb, input bit with_done);
        strb_t s;
        s.rel = 1; s.start = 1'b1; s.data = v.cmd;
        exp_strb.push_back(s);
        for (int k = 0; k < nstrb; k++) begin
            s.rel   = 1 + (k + 1) * int'(GAP + 1);
            s.start = 1'b0;
            s.data  = v.pl[k];
            exp_strb.push_back(s);
        end
        if (with_done) begin
            if (v.len == 0) exp_done.push_back(3);
            else            exp_done.push_back(1 + int'(v.len) * int'(GAP + 1) + 2);
        end
    endtask

    task automatic check_rsp_buffer();
        for (int k = 0; k < 16; k++) begin
            if (rsp_known[k]) begin
                bus_if.rsp_addr = 4'(k);
                #1;
                check($sformatf("rsp_buf[%0d]", k), 32'(bus_if.rsp_data), 32'(rsp_model[k]));
            end
        end
    endtask

    task automatic run_frame(input vec_t v, input bit do_write, input bit spam);
        int n;
        if (do_write) write_payload(v);
        push_expect(v, int'(v.len), 1'b1);
        t0 = cyc;
        bus_if.req_valid = 1'b1;
        bus_if.req_cmd   = v.cmd;
        bus_if.req_len   = v.len;
        @(negedge clk);
        bus_if.req_valid = spam;
        if (spam) begin
            bus_if.req_cmd = 8'hFF;
            bus_if.req_len = 4'd1;
            bus_if.pl_we   = 1'b1;
            bus_if.pl_addr = 4'd0;
            bus_if.pl_data = 8'hEE;
        end
        n = 0;
        while (bus_if.busy && n < 100) begin
            if (spam) check("req_ready_while_busy", 32'(bus_if.req_ready), 0);
            if (bus_if.rsp_done) begin
                bus_if.req_valid = 1'b0;
                bus_if.pl_we     = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus_if.req_valid = 1'b0;
        bus_if.pl_we     = 1'b0;
        check("frame_completes", 32'(n < 100), 1);
        check("req_ready_after", 32'(bus_if.req_ready), 1);
        repeat (3) @(negedge clk);
        check("strobes_drained", exp_strb.size(), 0);
        check("done_drained", exp_done.size(), 0);
        exp_strb.delete();
        exp_done.delete();
        for (int k = 0; k < int'(v.len); k++) begin
            rsp_model[k] = v.rsp[k];
            rsp_known[k] = 1'b1;
        end
        check_rsp_buffer();
    endtask

    vec_t vecs[4];
    vec_t va, vb, vr;

    initial begin
        int n;
        bus_if.req_valid = 1'b0;
        bus_if.req_cmd   = 8'h00;
        bus_if.req_len   = 4'd0;
        bus_if.pl_we     = 1'b0;
        bus_if.pl_addr   = 4'd0;
        bus_if.pl_data   = 8'h00;
        bus_if.rsp_addr  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            rsp_model[k] = 8'h00;
            rsp_known[k] = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            vecs[i].pl  = '0;
            vecs[i].rsp = '0;
        end
        vecs[0].cmd = 8'h00; vecs[0].len = 4'd3;
        vecs[0].pl[0] = 8'hA0; vecs[0].pl[1] = 8'hA1; vecs[0].pl[2] = 8'hA2;
        vecs[0].rsp[0] = 8'h5C; vecs[0].rsp[1] = 8'h42; vecs[0].rsp[2] = 8'h02;
        vecs[1].cmd = 8'h01; vecs[1].len = 4'd1;
        vecs[1].pl[0] = 8'h03; vecs[1].rsp[0] = 8'h59;
        vecs[2].cmd = 8'h04; vecs[2].len = 4'd2;
        vecs[2].pl[0] = 8'h53; vecs[2].pl[1] = 8'h02;
        vecs[2].rsp[0] = 8'h09; vecs[2].rsp[1] = 8'h58;
        vecs[3].cmd = 8'h05; vecs[3].len = 4'd0;

        repeat (3) @(negedge clk);
        check("reset_link_strobe", 32'(bus_if.link_strobe), 0);
        check("reset_link_start", 32'(bus_if.link_start), 0);
        check("reset_link_data", 32'(bus_if.link_data), 0);
        check("reset_rsp_done", 32'(bus_if.rsp_done), 0);
        check("reset_busy", 32'(bus_if.busy), 0);
        check("reset_req_ready", 32'(bus_if.req_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], 1'b1, 1'b0);
            if (vecs[i].cmd == 8'h01) check("responder_leds", 32'(leds), 32'h3);
            if (vecs[i].cmd == 8'h04) check("responder_scanlines", 32'(scanlines), 32'h2);
        end

        // Traffic while busy must be ignored; payload[0] is then replayed unwritten.
        va.cmd = 8'h02; va.len = 4'd3; va.pl = '0; va.rsp = '0;
        va.pl[0] = 8'h11; va.pl[1] = 8'h22; va.pl[2] = 8'h33;
        va.rsp[0] = 8'h4B; va.rsp[1] = 8'h78; va.rsp[2] = 8'h69;
        run_frame(va, 1'b1, 1'b1);
        vb.cmd = 8'h03; vb.len = 4'd1; vb.pl = '0; vb.rsp = '0;
        vb.pl[0] = 8'h11; vb.rsp[0] = 8'h4B;
        run_frame(vb, 1'b0, 1'b0);

        // Reset the cycle after the second strobe of a len=3 frame.
        vr = vecs[0];
        write_payload(vr);
        push_expect(vr, 1, 1'b0);
        t0 = cyc;
        bus_if.req_valid = 1'b1;
        bus_if.req_cmd   = vr.cmd;
        bus_if.req_len   = vr.len;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        n = 0;
        while ((cyc - t0) < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_point_reached", cyc - t0, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_link_strobe", 32'(bus_if.link_strobe), 0);
        check("midreset_busy", 32'(bus_if.busy), 0);
        check("midreset_req_ready", 32'(bus_if.req_ready), 1);
        repeat (20) @(negedge clk);
        check("midreset_strobes_drained", exp_strb.size(), 0);
        exp_strb.delete();
        for (int k = 0; k < 3; k++) rsp_known[k] = 1'b0;

        run_frame(vecs[2], 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/sysctrl_host.md
Name: sysctrl_host

Overview:
- Initiator side of the MCU byte-command link used by the system control block.
- Takes a command frame from local logic: a command byte plus 0..15 payload bytes held in a small buffer.
- Issues the frame as single-cycle byte strobes with a start flag on the command byte, and captures one response byte after each payload strobe.
- Used for boot-time configuration without the MCU, and as the stimulus engine in system benches.

Parameters:
GAP, 2, idle cycles between consecutive byte strobes (legal range 1..15)
DEPTH, 16, payload/response buffer depth (fixed 16; addresses 4 bits)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  frame request
req_ready  out  1  high when idle and able to accept
req_cmd  in  8  command byte
req_len  in  4  payload byte count 0..15
pl_we  in  1  payload buffer write strobe
pl_addr  in  4  payload buffer write address
pl_data  in  8  payload buffer write data
link_strobe  out  1  byte strobe toward responder, one cycle per byte
link_start  out  1  high with link_strobe on the command byte only
link_data  out  8  byte being sent
link_rdata  in  8  responder data_out
rsp_done  out  1  one-cycle pulse when frame completes
rsp_addr  in  4  response buffer read address
rsp_data  out  8  response byte, combinational read of rsp_addr
busy  out  1  frame in progress

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state IDLE
  - link_strobe=0, link_start=0, link_data=0
  - rsp_done=0, busy=0, req_ready=1
  - byte index=0, gap counter=0
  - Buffer contents are not reset.
- FSM states: IDLE, CMD, GAP, PAYLOAD, CAPTURE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_cmd and req_len, clear index, go to CMD.
- CMD (1 cycle): link_strobe=1, link_start=1, link_data=cmd. Then:
  - len=0: go to CAPTURE with no capture, which completes the frame.
  - otherwise: go to GAP.
- GAP:
  - Strobe low for exactly GAP cycles, then PAYLOAD.
  - Strobe-to-strobe spacing is GAP+1 cycles.
- PAYLOAD (1 cycle): link_strobe=1, link_start=0, link_data=payload[index]. Then CAPTURE.
- CAPTURE (1 cycle after the payload strobe):
  - Write response[index] <= link_rdata. The responder updates data_out on the strobe edge, so response k is what the responder produced for payload strobe k.
  - If index==len-1: go to DONE.
  - Else: index+1, gap counter reloads GAP-1 (CAPTURE counts as the first gap cycle), go to GAP.
- DONE (1 cycle): rsp_done=1, then IDLE.
- Output registering and hold:
  - link_data is registered.
  - link_data holds its last value between strobes.
  - link_start is never high without link_strobe.
- busy = (state != IDLE); req_ready = !busy.
- Buffer access:
  - Payload writes with pl_we while busy are ignored.
  - Writes in IDLE take effect the next cycle; a write in the same cycle as request acceptance is accepted.
- Latency, len=N≥1:
  - Accept at cycle 0; CMD strobe at cycle 1.
  - Payload strobe k at cycle 1+(k+1)(GAP+1).
  - rsp_done at cycle 1+N(GAP+1)+2.
- Latency, len=0: accept at cycle 0, CMD strobe at cycle 1, rsp_done at cycle 3.
- Response buffer entries at index ≥ len retain prior contents.
- req_valid while busy is ignored; no queuing.
- Reset mid-frame:
  - Returns to IDLE immediately; no further strobes.
  - Partially written response contents are undefined.
  - No rsp_done is issued.
- GAP outside 1..15: behaviour is not required.

Test Plan:
- CMD 0x00, len=3, GAP=2, against the sysctrl responder model -> strobes at cycles 1,4,7,10; start only at cycle 1; response[0..2]=0x5C,0x42,0x02; rsp_done at cycle 12.
- CMD 0x01, len=1, payload[0]=0x03 -> responder leds=2'b11; link_data=0x01 then 0x03; rsp_done at cycle 6.
- CMD 0x04, len=2, payload "S",0x02 -> responder scanlines=2; exactly 3 strobes, each one cycle wide.
- len=0, cmd 0x05 -> single strobe with start at cycle 1; rsp_done at cycle 3; response buffer unchanged.
- Second req_valid and pl_we asserted while busy -> neither accepted; payload[0] unchanged after the frame; req_ready low throughout.
- reset asserted the cycle after the second strobe of a len=3 frame -> next cycle link_strobe=0, busy=0, req_ready=1; no rsp_done.
